pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline. Decodes the instruction in ID and the ID/EX load status, and drives the PC enable, IF/ID enable and the IF/ID and ID/EX flushes. It also handshakes with the multicycle HI/LO divider for DIVU and keeps saturating stall and flush performance counters. It replaces per-stage ad-hoc stall counters with a single controller.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 20 ++
 rtl/pipe_hazard_ctrl_decode.sv | 40 ++++
 rtl/pipe_hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared opcode/funct constants and the hazard controller state type.
package pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_JR    = 6'd8;
  localparam logic [5:0] FN_DIVU  = 6'd27;

  typedef enum logic {
    S_RUN,
    S_DIV_WAIT
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_decode.sv
// Combinational decode of the ID instruction: control-flow class,
// divide detection and load-use hazard against the load sitting in EX.
module hazard_decode
  import pipe_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        idex_mem_read,
  input  logic [4:0]  idex_rt,
  output logic        is_jr,
  output logic        is_jump,
  output logic        is_divu,
  output logic        uses_rt,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic        lu_hazard
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_instr_bits;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign rs = instr[25:21];
  assign rt = instr[20:16];

  // The rd/shamt/immediate bits play no part in hazard detection.
  assign unused_instr_bits = ^instr[15:6];

  // Instruction class decode and the load-use comparison.
  always_comb begin
    is_jr     = (op == OP_RTYPE) && (fn == FN_JR);
    is_jump   = (op == OP_J) || (op == OP_JAL);
    is_divu   = (op == OP_RTYPE) && (fn == FN_DIVU);
    uses_rt   = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    lu_hazard = idex_mem_read && (idex_rt != 5'd0) &&
                ((idex_rt == rs) || (uses_rt && (idex_rt == rt)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer: RUN/DIV_WAIT FSM, divider watchdog and
// saturating stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int DIV_MAX = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       id_instr,
  input  logic              idex_mem_read,
  input  logic [4:0]        idex_rt,
  input  logic              ex_branch_taken,
  input  logic              div_busy,
  input  logic              div_done,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              div_start,
  output logic              div_timeout,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int              WD_W    = $clog2(DIV_MAX + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(DIV_MAX - 1);

  state_t          state;
  logic [WD_W-1:0] wd;

  logic       is_jr;
  logic       is_jump;
  logic       is_divu;
  logic       uses_rt;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       lu_hazard;
  logic       unused_fields;

  hazard_decode u_decode (
    .instr         (id_instr),
    .idex_mem_read (idex_mem_read),
    .idex_rt       (idex_rt),
    .is_jr         (is_jr),
    .is_jump       (is_jump),
    .is_divu       (is_divu),
    .uses_rt       (uses_rt),
    .rs            (id_rs),
    .rt            (id_rt),
    .lu_hazard     (lu_hazard)
  );

  // Register fields are already folded into lu_hazard inside the decoder.
  assign unused_fields = ^{id_rs, id_rt, uses_rt};

  // Pipeline control: Mealy priority chain in RUN, fixed stall in DIV_WAIT.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    div_start  = 1'b0;
    if (!rst) begin
      if (state == S_DIV_WAIT) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (is_divu && !div_busy) begin
        div_start = 1'b1;
      end else if (is_divu || lu_hazard) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (is_jr || is_jump) begin
        ifid_flush = 1'b1;
      end
    end
  end

  // FSM with divider watchdog; div_done beats a same-cycle watchdog expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      wd          <= '0;
      div_timeout <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (div_start) begin
            state <= S_DIV_WAIT;
            wd    <= '0;
          end
        end
        S_DIV_WAIT: begin
          if (div_done) begin
            state <= S_RUN;
            wd    <= '0;
          end else if (wd == WD_LAST) begin
            state       <= S_RUN;
            wd          <= '0;
            div_timeout <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

  // Saturating performance counters for stall and flush cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (ifid_flush && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int DIV_MAX = 40;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [31:0] NOP_I  = 32'h0000_0000;
  localparam logic [31:0] ADD_I  = {6'd0, 5'd2, 5'd4, 5'd3, 5'd0, 6'd32};
  localparam logic [31:0] J_I    = {6'd2, 26'd100};
  localparam logic [31:0] DIVU_I = {6'd0, 5'd5, 5'd6, 10'd0, 6'd27};

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       id_instr;
  logic              idex_mem_read;
  logic [4:0]        idex_rt;
  logic              ex_branch_taken;
  logic              div_busy;
  logic              div_done;
  logic              pc_en;
  logic              ifid_en;
  logic              ifid_flush;
  logic              idex_flush;
  logic              div_start;
  logic              div_timeout;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state, kept as plain integers.
  bit m_in_div  = 1'b0;
  int m_wait    = 0;
  bit m_timeout = 1'b0;
  int m_stall   = 0;
  int m_flush   = 0;

  bit e_pc_en, e_ifid_en, e_ifid_flush, e_idex_flush, e_div_start;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .DIV_MAX(DIV_MAX)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_instr        (id_instr),
    .idex_mem_read   (idex_mem_read),
    .idex_rt         (idex_rt),
    .ex_branch_taken (ex_branch_taken),
    .div_busy        (div_busy),
    .div_done        (div_done),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .div_start       (div_start),
    .div_timeout     (div_timeout),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected control outputs for the current cycle from the decode rules.
  task automatic predict(input bit r, input logic [31:0] instr, input bit mr,
                         input logic [4:0] irt, input bit br, input bit busy);
    logic [5:0] op, fn;
    logic [4:0] rs, rt;
    bit jr, jmp, divu, usesrt, lu;
    op = instr[31:26];
    fn = instr[5:0];
    rs = instr[25:21];
    rt = instr[20:16];
    jr     = (op == 0) && (fn == 8);
    jmp    = (op == 2) || (op == 3);
    divu   = (op == 0) && (fn == 27);
    usesrt = (op == 0) || (op == 4) || (op == 5) || (op == 43);
    lu     = mr && (irt != 0) && ((irt == rs) || (usesrt && (irt == rt)));
    {e_pc_en, e_ifid_en, e_ifid_flush, e_idex_flush, e_div_start} = 5'b11000;
    if (!r) begin
      if (m_in_div)               {e_pc_en, e_ifid_en, e_idex_flush} = 3'b001;
      else if (br)                {e_ifid_flush, e_idex_flush} = 2'b11;
      else if (divu && !busy)     e_div_start = 1'b1;
      else if (divu || lu)        {e_pc_en, e_ifid_en, e_idex_flush} = 3'b001;
      else if (jr || jmp)         e_ifid_flush = 1'b1;
    end
  endtask

  // Drive one cycle of inputs, check every output, then advance the model.
  task automatic applyStimulus(input bit r, input logic [31:0] instr, input bit mr,
                               input logic [4:0] irt, input bit br, input bit busy,
                               input bit done);
    rst             = r;
    id_instr        = instr;
    idex_mem_read   = mr;
    idex_rt         = irt;
    ex_branch_taken = br;
    div_busy        = busy;
    div_done        = done;
    #4;
    predict(r, instr, mr, irt, br, busy);
    checkOutput("pc_en",       32'(pc_en),       32'(e_pc_en));
    checkOutput("ifid_en",     32'(ifid_en),     32'(e_ifid_en));
    checkOutput("ifid_flush",  32'(ifid_flush),  32'(e_ifid_flush));
    checkOutput("idex_flush",  32'(idex_flush),  32'(e_idex_flush));
    checkOutput("div_start",   32'(div_start),   32'(e_div_start));
    checkOutput("div_timeout", 32'(div_timeout), 32'(m_timeout));
    checkOutput("stall_cnt",   32'(stall_cnt),   32'(m_stall));
    checkOutput("flush_cnt",   32'(flush_cnt),   32'(m_flush));
    if (r) begin
      m_in_div  = 1'b0;
      m_wait    = 0;
      m_timeout = 1'b0;
      m_stall   = 0;
      m_flush   = 0;
    end else begin
      if (!e_pc_en)     m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
      if (e_ifid_flush) m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
      if (m_in_div) begin
        m_wait++;
        if (done) begin
          m_in_div = 1'b0;
        end else if (m_wait == DIV_MAX) begin
          m_in_div  = 1'b0;
          m_timeout = 1'b1;
        end
      end else if (e_div_start) begin
        m_in_div = 1'b1;
        m_wait   = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] randInstr();
    logic [5:0] op, fn;
    logic [4:0] rs, rt;
    logic [31:0] w;
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    fn = 6'd32;
    case ($urandom_range(0, 7))
      0: begin op = 6'd0; fn = 6'd8;  end
      1: op = 6'd2;
      2: op = 6'd3;
      3: begin op = 6'd0; fn = 6'd27; end
      4: op = 6'd4;
      5: op = 6'd43;
      6: op = 6'd35;
      default: begin
        w = $urandom;
        op = w[31:26];
        fn = w[5:0];
      end
    endcase
    return {op, rs, rt, 10'd0, fn};
  endfunction

  initial begin
    rst = 1'b1; id_instr = NOP_I; idex_mem_read = 1'b0; idex_rt = 5'd0;
    ex_branch_taken = 1'b0; div_busy = 1'b0; div_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Load-use: one stall, then none when the load target is $0.
    applyStimulus(1, NOP_I, 0, 0, 0, 0, 0);
    applyStimulus(0, ADD_I, 1, 2, 0, 0, 0);
    checkOutput("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    applyStimulus(0, ADD_I, 0, 2, 0, 0, 0);
    applyStimulus(0, ADD_I, 1, 0, 0, 0, 0);
    checkOutput("lu_rt0_stall_cnt", 32'(stall_cnt), 32'd1);

    // Taken branch squashes a jump in ID: single flush, no extra bubble.
    applyStimulus(1, NOP_I, 0, 0, 0, 0, 0);
    applyStimulus(0, J_I, 0, 0, 1, 0, 0);
    applyStimulus(0, NOP_I, 0, 0, 0, 0, 0);
    checkOutput("br_flush_cnt", 32'(flush_cnt), 32'd1);

    // DIVU: start pulse, five stalls with div_done on the fifth.
    applyStimulus(1, NOP_I, 0, 0, 0, 0, 0);
    applyStimulus(0, DIVU_I, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++)
      applyStimulus(0, DIVU_I, 0, 0, 1, 1, (i == 5));
    checkOutput("divu_stall_cnt", 32'(stall_cnt), 32'd5);
    checkOutput("divu_resume_pc_en", 32'(pc_en), 32'd1);
    applyStimulus(0, NOP_I, 0, 0, 0, 0, 0);

    // Divider never answers: watchdog expires after DIV_MAX wait cycles.
    applyStimulus(1, NOP_I, 0, 0, 0, 0, 0);
    applyStimulus(0, DIVU_I, 0, 0, 0, 0, 0);
    for (int i = 1; i <= DIV_MAX; i++)
      applyStimulus(0, NOP_I, 0, 0, 0, 1, 0);
    checkOutput("wd_timeout", 32'(div_timeout), 32'd1);
    applyStimulus(0, NOP_I, 0, 0, 0, 0, 0);

    // Reset on the third wait cycle aborts back to RUN with cleared counters.
    applyStimulus(1, NOP_I, 0, 0, 0, 0, 0);
    applyStimulus(0, DIVU_I, 0, 0, 0, 0, 0);
    applyStimulus(0, NOP_I, 0, 0, 0, 1, 0);
    applyStimulus(0, NOP_I, 0, 0, 0, 1, 0);
    applyStimulus(1, NOP_I, 0, 0, 0, 1, 0);
    checkOutput("rst_abort_stall_cnt", 32'(stall_cnt), 32'd0);
    applyStimulus(0, NOP_I, 0, 0, 0, 0, 0);

    // Twenty back-to-back load-use stalls saturate the 4-bit counter.
    applyStimulus(1, NOP_I, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      applyStimulus(0, ADD_I, 1, 2, 0, 0, 0);
    checkOutput("sat_stall_cnt", 32'(stall_cnt), 32'd15);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0), randInstr(),
                    ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                    m_in_div ? ($urandom_range(0, 6) == 0) : ($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
